vm2002_coin_acceptor: RTL and testbench
=======================================

VM2002_COIN_ACCEPTOR -- requirements
Module: vm2002_coin_acceptor

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: idle cycles in COLLECT before timeout.
REQ-002 Parameter MAX_CREDIT, default 200: credit ceiling, in cents.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 hrst_n  input  1  reset, asynchronous and active-low.
REQ-005 srst  input  1  synchronous soft reset, active-high.
REQ-006 insert_coins  input  1  machine requests payment; level.
REQ-007 start_timer  input  1  machine opens the selection window; level.
REQ-008 coin_valid  input  1  one-cycle coin strobe.
REQ-009 coin_type  input  2  coin denomination: 00=5, 01=10, 10=25, 11=100 cents.
REQ-010 select  input  1  user confirms purchase; level, sampled each cycle.
REQ-011 price  input  8  price of the selected item in cents; stable while select=1.
REQ-012 credit  output  8  accumulated credit in cents.
REQ-013 coin_reject  output  1  one-cycle pulse when a coin is refused.
REQ-014 insufficient_amount  output  1  credit below price at the last check; level.
REQ-015 paid  output  1  one-cycle pulse when a purchase completes.
REQ-016 change  output  8  refund or change amount; valid while paid or timeout is high.
REQ-017 timeout  output  1  selection window expired; level.

Function
REQ-018 FSM states: IDLE, COLLECT, CHECK, DONE, EXPIRED.
REQ-019 IDLE to COLLECT when insert_coins=1 and start_timer=1; credit is cleared and the timer is loaded with TIMEOUT_CYCLES.
REQ-020 In COLLECT, each coin_valid adds its value to credit in the next cycle and reloads the timer.
REQ-021 If credit plus the coin value exceeds MAX_CREDIT, the coin is refused: coin_reject pulses in the next cycle and credit is unchanged.
REQ-022 coin_valid is ignored outside COLLECT: no credit change and no coin_reject.
REQ-023 In COLLECT with select=1, the FSM moves to CHECK; a coin in the same cycle is credited first, so CHECK uses the updated credit.
REQ-024 CHECK lasts exactly one cycle.
REQ-025 In CHECK, if credit >= price: paid pulses, change = credit - price, credit is cleared, insufficient_amount is cleared, and the FSM moves to DONE.
REQ-026 In CHECK, if credit < price: insufficient_amount goes high, the timer is reloaded, and the FSM returns to COLLECT.
REQ-027 insufficient_amount stays high until the next CHECK, the next IDLE entry, or a reset.
REQ-028 The timer decrements once per COLLECT cycle that has no coin_valid and no select.
REQ-029 When the timer reaches 0: the FSM moves to EXPIRED, timeout goes high, change = credit, and credit is cleared.
REQ-030 If select and timer expiry occur in the same cycle, select wins and the FSM moves to CHECK.
REQ-031 DONE and EXPIRED hold their outputs and return to IDLE when start_timer=0; timeout falls on the IDLE entry.
REQ-032 If start_timer falls while in COLLECT, the FSM aborts to IDLE and credit is cleared; no refund is signalled.
REQ-033 Credit and change are 8-bit unsigned; the adder is 9 bits wide so the MAX_CREDIT comparison cannot wrap.

Reset
REQ-034 hrst_n=0 asynchronously forces state=IDLE and sets all outputs to 0 (credit, change, coin_reject, paid, insufficient_amount, timeout); the timer is set to 0.
REQ-035 srst=1 has the same effect as REQ-034 but on the next posedge, in any state, including mid-COLLECT.
REQ-036 srst takes priority over coin_valid, select and timer expiry in the same cycle.

Structure
REQ-037 The coin_t enum, the coin value constants (5/10/25/100) and the acceptor state enum live in vm2002_common_pkg.
REQ-038 Timer is sub-module vm2002_timeout_timer: inputs load, dec, clr; output expired; parameterised by TIMEOUT_CYCLES.

Verification
REQ-039 Quarter, quarter, dime, then select with price=50 -> credit 60; paid pulse; change=10; credit=0.
REQ-040 One dime, then select with price=25 -> insufficient_amount=1; back in COLLECT; adding a quarter and selecting again -> paid and change=10.
REQ-041 Two dollars (credit 200) then a nickel -> coin_reject pulse; credit stays 200.
REQ-042 One quarter, no further input for TIMEOUT_CYCLES cycles -> timeout=1 and change=25; deasserting start_timer returns to IDLE and clears timeout.
REQ-043 A coin arriving in the same cycle as select (price=10, credit 0, dime) -> paid and change=0.
REQ-044 srst pulse mid-COLLECT with credit 35 -> next cycle IDLE with all outputs 0; hrst_n low mid-CHECK -> immediate IDLE.

Source files
------------

// File: rtl/vm2002_common_pkg.sv
// vm2002_common_pkg
// Shared types for the vm2002 coin acceptor: coin denominations, their
// values in cents, and the acceptor state encoding.
package vm2002_common_pkg;

    typedef enum logic [1:0] {
        COIN_NICKEL  = 2'b00,
        COIN_DIME    = 2'b01,
        COIN_QUARTER = 2'b10,
        COIN_DOLLAR  = 2'b11
    } coin_t;

    localparam logic [7:0] COIN_VAL_NICKEL  = 8'd5;
    localparam logic [7:0] COIN_VAL_DIME    = 8'd10;
    localparam logic [7:0] COIN_VAL_QUARTER = 8'd25;
    localparam logic [7:0] COIN_VAL_DOLLAR  = 8'd100;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_CHECK   = 3'd2,
        ST_DONE    = 3'd3,
        ST_EXPIRED = 3'd4
    } acceptor_state_t;

    // Value in cents of a coin denomination.
    function automatic logic [7:0] coin_value(input coin_t c);
        logic [7:0] v;
        v = COIN_VAL_NICKEL;
        case (c)
            COIN_NICKEL:  v = COIN_VAL_NICKEL;
            COIN_DIME:    v = COIN_VAL_DIME;
            COIN_QUARTER: v = COIN_VAL_QUARTER;
            COIN_DOLLAR:  v = COIN_VAL_DOLLAR;
            default:      v = COIN_VAL_NICKEL;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vm2002_timeout_timer.sv
// vm2002_timeout_timer
// Inactivity down-counter for the coin acceptor selection window.
// Ports:
//   clk      clock
//   hrst_n   asynchronous active-low reset (count -> 0)
//   clr      synchronous clear (count -> 0), highest priority
//   load     reload count with TIMEOUT_CYCLES
//   dec      one idle cycle elapsed
//   expired  asserted in the idle cycle whose decrement brings the count to 0
module vm2002_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic hrst_n,
    input  logic clr,
    input  logic load,
    input  logic dec,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= CW'(TIMEOUT_CYCLES);
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - CW'(1);
        end
    end

    // Flagged combinationally so the FSM leaves COLLECT on the same edge the
    // count hits zero: exactly TIMEOUT_CYCLES idle cycles after a (re)load.
    assign expired = dec && (count_reg <= CW'(1));

endmodule

// File: rtl/vm2002_coin_acceptor.sv
// vm2002_coin_acceptor
// Coin acceptor FSM for the vm2002 vending machine: collects coins up to a
// credit ceiling, checks credit against the selected price, and returns
// change on purchase or a refund when the selection window times out.
// Ports:
//   clk, hrst_n (async active-low), srst (sync active-high)
//   insert_coins, start_timer         machine control levels
//   coin_valid, coin_type[1:0]        coin strobe and denomination
//   select, price[7:0]                purchase request and item price
//   credit[7:0]                       accumulated credit (cents)
//   coin_reject                       1-cycle pulse, coin refused
//   insufficient_amount               level, last check was short
//   paid                              1-cycle pulse, purchase completed
//   change[7:0]                       change/refund, valid with paid/timeout
//   timeout                           level, selection window expired
module vm2002_coin_acceptor
    import vm2002_common_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_CREDIT     = 200
) (
    input  logic       clk,
    input  logic       hrst_n,
    input  logic       srst,
    input  logic       insert_coins,
    input  logic       start_timer,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       select,
    input  logic [7:0] price,
    output logic [7:0] credit,
    output logic       coin_reject,
    output logic       insufficient_amount,
    output logic       paid,
    output logic [7:0] change,
    output logic       timeout
);

    acceptor_state_t state_reg;
    logic [7:0]      credit_reg;
    logic [7:0]      change_reg;
    logic            coin_reject_reg;
    logic            paid_reg;
    logic            insufficient_reg;
    logic            timeout_reg;

    logic [7:0] coin_val;
    logic [8:0] coin_sum;
    logic       coin_fits;
    logic       in_collect;
    logic       timer_load;
    logic       timer_dec;
    logic       timer_expired;

    // 9-bit sum so the ceiling comparison cannot wrap.
    assign coin_val  = coin_value(coin_t'(coin_type));
    assign coin_sum  = {1'b0, credit_reg} + {1'b0, coin_val};
    assign coin_fits = (coin_sum <= 9'(MAX_CREDIT));

    // COLLECT only counts as active while the machine keeps the window open.
    assign in_collect = (state_reg == ST_COLLECT) && start_timer;

    // Any coin (accepted or refused) counts as activity and restarts the window.
    assign timer_load = ((state_reg == ST_IDLE) && insert_coins && start_timer)
                     || (in_collect && coin_valid)
                     || ((state_reg == ST_CHECK) && (credit_reg < price));
    assign timer_dec  = in_collect && !coin_valid && !select;

    vm2002_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .hrst_n  (hrst_n),
        .clr     (srst),
        .load    (timer_load),
        .dec     (timer_dec),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            state_reg        <= ST_IDLE;
            credit_reg       <= '0;
            change_reg       <= '0;
            coin_reject_reg  <= 1'b0;
            paid_reg         <= 1'b0;
            insufficient_reg <= 1'b0;
            timeout_reg      <= 1'b0;
        end else if (srst) begin
            state_reg        <= ST_IDLE;
            credit_reg       <= '0;
            change_reg       <= '0;
            coin_reject_reg  <= 1'b0;
            paid_reg         <= 1'b0;
            insufficient_reg <= 1'b0;
            timeout_reg      <= 1'b0;
        end else begin
            coin_reject_reg <= 1'b0;
            paid_reg        <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (insert_coins && start_timer) begin
                        state_reg  <= ST_COLLECT;
                        credit_reg <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (!start_timer) begin
                        // Abort: credit is dropped without a refund.
                        state_reg        <= ST_IDLE;
                        credit_reg       <= '0;
                        change_reg       <= '0;
                        insufficient_reg <= 1'b0;
                    end else begin
                        if (coin_valid) begin
                            if (coin_fits) begin
                                credit_reg <= coin_sum[7:0];
                            end else begin
                                coin_reject_reg <= 1'b1;
                            end
                        end
                        // Expiry only fires on idle cycles, so select always wins.
                        if (select) begin
                            state_reg <= ST_CHECK;
                        end else if (timer_expired) begin
                            state_reg   <= ST_EXPIRED;
                            timeout_reg <= 1'b1;
                            change_reg  <= credit_reg;
                            credit_reg  <= '0;
                        end
                    end
                end
                ST_CHECK: begin
                    if (credit_reg >= price) begin
                        state_reg        <= ST_DONE;
                        paid_reg         <= 1'b1;
                        change_reg       <= credit_reg - price;
                        credit_reg       <= '0;
                        insufficient_reg <= 1'b0;
                    end else begin
                        state_reg        <= ST_COLLECT;
                        insufficient_reg <= 1'b1;
                    end
                end
                ST_DONE, ST_EXPIRED: begin
                    if (!start_timer) begin
                        state_reg        <= ST_IDLE;
                        timeout_reg      <= 1'b0;
                        change_reg       <= '0;
                        insufficient_reg <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign credit              = credit_reg;
    assign change              = change_reg;
    assign coin_reject         = coin_reject_reg;
    assign paid                = paid_reg;
    assign insufficient_amount = insufficient_reg;
    assign timeout             = timeout_reg;

endmodule

// File: tb/tb_vm2002_coin_acceptor.sv
// tb_vm2002_coin_acceptor
// Self-checking bench: directed scenarios with literal expectations followed
// by randomized traffic, all compared every cycle against a behavioural model.
module tb_vm2002_coin_acceptor;

    localparam int TO      = 20;
    localparam int MAXC    = 200;

    localparam int P_IDLE    = 0;
    localparam int P_COLLECT = 1;
    localparam int P_CHECK   = 2;
    localparam int P_DONE    = 3;
    localparam int P_EXPIRED = 4;

    logic       clk = 1'b0;
    logic       hrst_n = 1'b0;
    logic       srst = 1'b0;
    logic       insert_coins = 1'b0;
    logic       start_timer = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'b00;
    logic       select = 1'b0;
    logic [7:0] price = 8'd0;
    logic [7:0] credit;
    logic       coin_reject;
    logic       insufficient_amount;
    logic       paid;
    logic [7:0] change;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model
    int m_phase, m_credit, m_change, m_reject, m_paid, m_insuf, m_timeout;
    int m_idle_run;
    int coin_cents [4] = '{5, 10, 25, 100};

    vm2002_coin_acceptor #(
        .TIMEOUT_CYCLES(TO),
        .MAX_CREDIT    (MAXC)
    ) dut (
        .clk                 (clk),
        .hrst_n              (hrst_n),
        .srst                (srst),
        .insert_coins        (insert_coins),
        .start_timer         (start_timer),
        .coin_valid          (coin_valid),
        .coin_type           (coin_type),
        .select              (select),
        .price               (price),
        .credit              (credit),
        .coin_reject         (coin_reject),
        .insufficient_amount (insufficient_amount),
        .paid                (paid),
        .change              (change),
        .timeout             (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_credit = 0; m_change = 0; m_reject = 0;
        m_paid = 0; m_insuf = 0; m_timeout = 0; m_idle_run = 0;
    endtask

    // One clock of the acceptor's rules, from the inputs present at the edge.
    task automatic model_step();
        int val;
        if (srst) begin
            model_reset();
            return;
        end
        m_reject = 0;
        m_paid   = 0;
        case (m_phase)
            P_IDLE: if (insert_coins && start_timer) begin
                m_phase = P_COLLECT; m_credit = 0; m_idle_run = 0;
            end
            P_COLLECT: begin
                if (!start_timer) begin
                    m_phase = P_IDLE; m_credit = 0; m_change = 0; m_insuf = 0;
                end else if (coin_valid || select) begin
                    if (coin_valid) begin
                        val = coin_cents[coin_type];
                        if (m_credit + val > MAXC) m_reject = 1;
                        else m_credit += val;
                        m_idle_run = 0;
                    end
                    if (select) m_phase = P_CHECK;
                end else begin
                    m_idle_run++;
                    if (m_idle_run >= TO) begin
                        m_phase = P_EXPIRED; m_timeout = 1;
                        m_change = m_credit; m_credit = 0;
                    end
                end
            end
            P_CHECK: begin
                if (m_credit >= int'(price)) begin
                    m_paid = 1; m_change = m_credit - int'(price);
                    m_credit = 0; m_insuf = 0; m_phase = P_DONE;
                end else begin
                    m_insuf = 1; m_idle_run = 0; m_phase = P_COLLECT;
                end
            end
            default: if (!start_timer) begin
                m_phase = P_IDLE; m_timeout = 0; m_change = 0; m_insuf = 0;
            end
        endcase
    endtask

    task automatic compare_all();
        check("credit", int'(credit), m_credit);
        check("coin_reject", int'(coin_reject), m_reject);
        check("insufficient_amount", int'(insufficient_amount), m_insuf);
        check("paid", int'(paid), m_paid);
        check("timeout", int'(timeout), m_timeout);
        if (m_paid != 0 || m_timeout != 0)
            check("change", int'(change), m_change);
    endtask

    task automatic step(input logic ins, input logic st, input logic cv,
                        input logic [1:0] ct, input logic sel,
                        input logic [7:0] pr, input logic sr);
        @(negedge clk);
        insert_coins = ins; start_timer = st; coin_valid = cv;
        coin_type = ct; select = sel; price = pr; srst = sr;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // Shorthands for common directed cycles (machine window held open).
    task automatic coin(input logic [1:0] ct, input logic [7:0] pr);
        step(1'b1, 1'b1, 1'b1, ct, 1'b0, pr, 1'b0);
    endtask
    task automatic idle(input logic [7:0] pr);
        step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, pr, 1'b0);
    endtask
    task automatic sel(input logic [7:0] pr);
        step(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, pr, 1'b0);
    endtask
    task automatic close_window();
        step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 1'b0);
    endtask

    initial begin
        bit quiet;
        logic ins_r, st_r, cv_r, sel_r, sr_r;
        logic [1:0] ct_r;
        logic [7:0] pr_r;

        model_reset();
        #12;
        check("rst_credit", int'(credit), 0);
        check("rst_paid", int'(paid), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_change", int'(change), 0);
        @(negedge clk);
        hrst_n = 1'b1;

        // Quarter, quarter, dime, buy at 50.
        idle(8'd50);
        coin(2'b10, 8'd50); coin(2'b10, 8'd50); coin(2'b01, 8'd50);
        check("r039_credit60", int'(credit), 60);
        sel(8'd50);
        idle(8'd50);
        check("r039_paid", int'(paid), 1);
        check("r039_change", int'(change), 10);
        check("r039_credit0", int'(credit), 0);
        idle(8'd50);
        check("r039_paid_pulse", int'(paid), 0);
        close_window();

        // Dime short of 25, then quarter added.
        idle(8'd25);
        coin(2'b01, 8'd25);
        sel(8'd25);
        idle(8'd25);
        check("r040_insuf", int'(insufficient_amount), 1);
        check("r040_credit10", int'(credit), 10);
        coin(2'b10, 8'd25);
        check("r040_credit35", int'(credit), 35);
        sel(8'd25);
        idle(8'd25);
        check("r040_paid", int'(paid), 1);
        check("r040_change", int'(change), 10);
        check("r040_insuf_clr", int'(insufficient_amount), 0);
        close_window();

        // Ceiling: 200 then nickel refused.
        idle(8'd0);
        coin(2'b11, 8'd0); coin(2'b11, 8'd0);
        check("r041_credit200", int'(credit), 200);
        coin(2'b00, 8'd0);
        check("r041_reject", int'(coin_reject), 1);
        check("r041_credit_held", int'(credit), 200);
        idle(8'd0);
        check("r041_reject_pulse", int'(coin_reject), 0);
        close_window();

        // Timeout refund of a quarter.
        idle(8'd0);
        coin(2'b10, 8'd0);
        for (int i = 0; i < TO - 1; i++) idle(8'd0);
        check("r042_not_yet", int'(timeout), 0);
        idle(8'd0);
        check("r042_timeout", int'(timeout), 1);
        check("r042_change", int'(change), 25);
        check("r042_credit0", int'(credit), 0);
        close_window();
        check("r042_timeout_clr", int'(timeout), 0);

        // Coin together with select.
        idle(8'd10);
        step(1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 8'd10, 1'b0);
        check("r043_credit10", int'(credit), 10);
        idle(8'd10);
        check("r043_paid", int'(paid), 1);
        check("r043_change0", int'(change), 0);
        close_window();

        // Soft reset mid-COLLECT with 35.
        idle(8'd0);
        coin(2'b10, 8'd0); coin(2'b01, 8'd0);
        check("r044_credit35", int'(credit), 35);
        step(1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 8'd0, 1'b1);
        check("r044_srst_credit", int'(credit), 0);
        check("r044_srst_reject", int'(coin_reject), 0);

        // Hard reset mid-CHECK: credit must clear without a clock edge.
        close_window();
        idle(8'd100);
        coin(2'b10, 8'd100);
        sel(8'd100);
        @(negedge clk);
        hrst_n = 1'b0;
        #2;
        model_reset();
        check("r044_hrst_credit", int'(credit), 0);
        check("r044_hrst_insuf", int'(insufficient_amount), 0);
        @(negedge clk);
        hrst_n = 1'b1;
        idle(8'd100);
        check("r044_after_enter", int'(credit), 0);
        close_window();

        // Randomized traffic; price only changes while idle so it is stable
        // across any select.
        pr_r = 8'd0;
        for (int blk = 0; blk < 60; blk++) begin
            quiet = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < 50; k++) begin
                if (m_phase == P_IDLE) pr_r = 8'($urandom_range(0, 210));
                ins_r = ($urandom_range(0, 3) != 0);
                st_r  = ($urandom_range(0, 29) != 0);
                cv_r  = quiet ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 2) == 0);
                sel_r = quiet ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 9) == 0);
                sr_r  = ($urandom_range(0, 299) == 0);
                ct_r  = 2'($urandom_range(0, 3));
                step(ins_r, st_r, cv_r, ct_r, sel_r, pr_r, sr_r);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
